// File: rtl/bt_cigar_walker.sv
// bt_cigar_walker: walks a stored backtrace from (i_end,j_end) to the origin
// and streams run-length CIGAR beats. Option macro: BT_WALK_ERR_CHECK_EN.
module bt_cigar_walker #(
  parameter int BT_WIDTH  = 8,
  parameter int IDX_WIDTH = 12,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] i_end,
  input  logic [IDX_WIDTH-1:0] j_end,
  output logic                 busy,
  output logic                 done,
  output logic                 bt_rd_en,
  output logic [IDX_WIDTH-1:0] bt_rd_i,
  output logic [IDX_WIDTH-1:0] bt_rd_j,
  input  logic [BT_WIDTH-1:0]  bt_rd_data,
  output logic                 cigar_valid,
  input  logic                 cigar_ready,
  output logic [1:0]           cigar_op,
  output logic [LEN_WIDTH-1:0] cigar_len,
  output logic                 cigar_last,
  output logic                 err
);

  localparam logic [1:0] OP_M = 2'd0;
  localparam logic [1:0] OP_D = 2'd1;
  localparam logic [1:0] OP_I = 2'd2;
  localparam int CW =
    ((IDX_WIDTH > LEN_WIDTH) ? IDX_WIDTH : LEN_WIDTH) + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_EMIT,
    S_TAIL,
    S_FLUSH
  } state_t;

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 rd_en_q;
  logic [IDX_WIDTH-1:0] rd_i_q;
  logic [IDX_WIDTH-1:0] rd_j_q;
  logic                 cv_q;
  logic [1:0]           cop_q;
  logic [LEN_WIDTH-1:0] clen_q;
  logic                 clast_q;
  logic [IDX_WIDTH-1:0] i_q;
  logic [IDX_WIDTH-1:0] j_q;
  logic                 run_vld_q;
  logic [1:0]           run_op_q;
  logic [LEN_WIDTH-1:0] run_len_q;
`ifdef BT_WALK_ERR_CHECK_EN
  logic                 err_q;
  logic                 dec_bad;
`else
  logic                 unused_rd;
`endif

  logic [1:0]           dec_op;
  logic [IDX_WIDTH-1:0] ni;
  logic [IDX_WIDTH-1:0] nj;
  logic                 can_merge;
  logic [1:0]           tail_op;
  logic [IDX_WIDTH-1:0] tail_cnt;
  logic [LEN_WIDTH-1:0] tail_base;
  logic [LEN_WIDTH-1:0] tail_room;
  logic [LEN_WIDTH-1:0] tail_sum;
  logic [IDX_WIDTH-1:0] tail_rem;
  logic                 tail_fits;

  // Decode the direction code returned for the cell just fetched.
  always_comb begin
    dec_op = OP_M;
`ifdef BT_WALK_ERR_CHECK_EN
    dec_bad = 1'b0;
    if (bt_rd_data > BT_WIDTH'(2)) begin
      dec_bad = 1'b1;
    end else begin
      dec_op = bt_rd_data[1:0];
    end
`else
    if (bt_rd_data[1:0] != 2'd3) begin
      dec_op = bt_rd_data[1:0];
    end
`endif
  end

`ifndef BT_WALK_ERR_CHECK_EN
  assign unused_rd = ^bt_rd_data;
`endif

  assign ni = i_q - IDX_WIDTH'(dec_op != OP_D);
  assign nj = j_q - IDX_WIDTH'(dec_op != OP_I);
  assign can_merge = run_vld_q && (run_op_q == dec_op)
                     && (run_len_q != LEN_MAX);

  // Tail appends the remaining bases on one axis, a beat's worth per cycle.
  assign tail_op   = (i_q == '0) ? OP_D : OP_I;
  assign tail_cnt  = (i_q == '0) ? j_q : i_q;
  assign tail_base = run_vld_q ? run_len_q : '0;
  assign tail_room = LEN_MAX - tail_base;
  assign tail_fits = CW'(tail_cnt) <= CW'(tail_room);
  assign tail_sum  = tail_base + LEN_WIDTH'(tail_cnt);
  assign tail_rem  = IDX_WIDTH'(CW'(tail_cnt) - CW'(tail_room));

  // Walker state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_i_q    <= '0;
      rd_j_q    <= '0;
      cv_q      <= 1'b0;
      cop_q     <= OP_M;
      clen_q    <= '0;
      clast_q   <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      run_vld_q <= 1'b0;
      run_op_q  <= OP_M;
      run_len_q <= '0;
`ifdef BT_WALK_ERR_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
`ifdef BT_WALK_ERR_CHECK_EN
            err_q <= 1'b0;
`endif
            i_q       <= i_end;
            j_q       <= j_end;
            run_vld_q <= 1'b0;
            if (i_end == '0 && j_end == '0) begin
              done_q <= 1'b1;
            end else if (i_end == '0 || j_end == '0) begin
              busy_q  <= 1'b1;
              state_q <= S_TAIL;
            end else begin
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
              rd_i_q  <= i_end;
              rd_j_q  <= j_end;
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          rd_en_q <= 1'b0;
          state_q <= S_EVAL;
        end
        S_EVAL: begin
`ifdef BT_WALK_ERR_CHECK_EN
          if (dec_bad) begin
            err_q <= 1'b1;
            if (run_vld_q) begin
              cv_q      <= 1'b1;
              cop_q     <= run_op_q;
              clen_q    <= run_len_q;
              clast_q   <= 1'b1;
              run_vld_q <= 1'b0;
              state_q   <= S_EMIT;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
`else
          begin
`endif
            i_q <= ni;
            j_q <= nj;
            if (can_merge) begin
              run_len_q <= run_len_q + 1'b1;
            end else begin
              run_op_q  <= dec_op;
              run_len_q <= LEN_WIDTH'(1);
              run_vld_q <= 1'b1;
            end
            if (run_vld_q && !can_merge) begin
              cv_q    <= 1'b1;
              cop_q   <= run_op_q;
              clen_q  <= run_len_q;
              clast_q <= 1'b0;
              state_q <= S_EMIT;
            end else if (ni != '0 && nj != '0) begin
              rd_en_q <= 1'b1;
              rd_i_q  <= ni;
              rd_j_q  <= nj;
              state_q <= S_FETCH;
            end else begin
              state_q <= S_TAIL;
            end
          end
        end
        S_EMIT: begin
          if (cigar_ready) begin
            cv_q    <= 1'b0;
            clast_q <= 1'b0;
            if (clast_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else if (i_q != '0 && j_q != '0) begin
              rd_en_q <= 1'b1;
              rd_i_q  <= i_q;
              rd_j_q  <= j_q;
              state_q <= S_FETCH;
            end else begin
              state_q <= S_TAIL;
            end
          end
        end
        S_TAIL: begin
          if (i_q == '0 && j_q == '0) begin
            state_q <= S_FLUSH;
          end else if (run_vld_q && run_op_q != tail_op) begin
            cv_q      <= 1'b1;
            cop_q     <= run_op_q;
            clen_q    <= run_len_q;
            clast_q   <= 1'b0;
            run_vld_q <= 1'b0;
            state_q   <= S_EMIT;
          end else if (tail_fits) begin
            run_op_q  <= tail_op;
            run_len_q <= tail_sum;
            run_vld_q <= 1'b1;
            i_q       <= '0;
            j_q       <= '0;
          end else begin
            cv_q      <= 1'b1;
            cop_q     <= tail_op;
            clen_q    <= LEN_MAX;
            clast_q   <= 1'b0;
            run_vld_q <= 1'b0;
            if (i_q == '0) begin
              j_q <= tail_rem;
            end else begin
              i_q <= tail_rem;
            end
            state_q <= S_EMIT;
          end
        end
        S_FLUSH: begin
          if (run_vld_q) begin
            cv_q      <= 1'b1;
            cop_q     <= run_op_q;
            clen_q    <= run_len_q;
            clast_q   <= 1'b1;
            run_vld_q <= 1'b0;
            state_q   <= S_EMIT;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign bt_rd_en    = rd_en_q;
  assign bt_rd_i     = rd_i_q;
  assign bt_rd_j     = rd_j_q;
  assign cigar_valid = cv_q;
  assign cigar_op    = cop_q;
  assign cigar_len   = clen_q;
  assign cigar_last  = clast_q;
`ifdef BT_WALK_ERR_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
